// File: rtl/mgt_01_alu_scheduler_pkg.sv
// Shared types for the ALU scheduler: operation encoding, data views,
// scheduler states and the combinational core ALU.
package mgt_01_alu_scheduler_pkg;

  localparam int SCHED_MAX_REQ = 8;
  localparam int SCHED_ID_W    = $clog2(SCHED_MAX_REQ);
  localparam int ALU_OP_W      = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_XOR = 4'h2,
    ALU_OR  = 4'h3,
    ALU_AND = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_EQ  = 4'h8,
    ALU_NE  = 4'h9,
    ALU_LT  = 4'hA,
    ALU_LTU = 4'hB,
    ALU_GE  = 4'hC,
    ALU_GEU = 4'hD
  } alu_ops_e;

  typedef logic [31:0] data_bus_t;

  typedef union packed {
    data_bus_t          raw;
    logic signed [31:0] sgn;
  } data_u;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  typedef struct packed {
    data_bus_t result;
    logic      cmp;
  } alu_out_t;

  // Compare ops report through cmp only; shifts take the whole of operand B,
  // so amounts of 32 or more flush the value out (sign-fill for SRA).
  function automatic alu_out_t alu_eval(alu_ops_e op, data_u a, data_u b);
    alu_out_t r;
    r.result = '0;
    r.cmp    = 1'b0;
    case (op)
      ALU_ADD: r.result = a.raw + b.raw;
      ALU_SUB: r.result = a.raw - b.raw;
      ALU_XOR: r.result = a.raw ^ b.raw;
      ALU_OR:  r.result = a.raw | b.raw;
      ALU_AND: r.result = a.raw & b.raw;
      ALU_SLL: r.result = a.raw << b.raw;
      ALU_SRL: r.result = a.raw >> b.raw;
      ALU_SRA: r.result = a.sgn >>> b.raw;
      ALU_EQ:  r.cmp    = (a.raw == b.raw);
      ALU_NE:  r.cmp    = (a.raw != b.raw);
      ALU_LT:  r.cmp    = (a.sgn < b.sgn);
      ALU_LTU: r.cmp    = (a.raw < b.raw);
      ALU_GE:  r.cmp    = (a.sgn >= b.sgn);
      ALU_GEU: r.cmp    = (a.raw >= b.raw);
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mgt_01_rr_arbiter.sv
// Round-robin / fixed-priority arbiter: one-hot grant plus binary index,
// searching upward from the pointer and wrapping at NUM_REQ-1.
module mgt_01_rr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(NUM_REQ);

  int   base;
  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    base  = (FIXED_PRIO != 0) ? 0 : int'(ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = base + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mgt_01_alu_scheduler.sv
// Shares the core ALU among NUM_REQ requesters with optional locked
// sequences and a one-entry registered response buffer.
module mgt_01_alu_scheduler
  import mgt_01_alu_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int FIXED_PRIO   = 0,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0]                req_lock_i,
  input  logic [NUM_REQ-1:0][31:0]          req_op_a_i,
  input  logic [NUM_REQ-1:0][31:0]          req_op_b_i,
  input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]  req_ops_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [31:0]                       rsp_result_o,
  output logic                              rsp_cmp_o,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id_o,
  output logic                              lock_abort_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT);

  sched_state_e       state, state_next;
  logic [ID_W-1:0]    ptr, ptr_next;
  logic [ID_W-1:0]    owner, owner_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ID_W-1:0]    win, win_inc, owner_inc;
  logic [NUM_REQ-1:0] arb_req, grant, owner_mask;
  logic               can_accept, hs, abort;
  alu_out_t           alu_res;

  assign can_accept = ~rsp_valid_o | rsp_ready_i;
  assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

  // While locked only the owner may compete; a full buffer blocks everyone.
  assign arb_req = !can_accept        ? '0 :
                   (state == LOCKED)  ? (req_valid_i & owner_mask) :
                                        req_valid_i;

  mgt_01_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win)
  );

  assign req_ready_o  = grant;
  assign hs           = |grant;
  assign win_inc      = (win   == ID_W'(NUM_REQ-1)) ? '0 : win   + 1'b1;
  assign owner_inc    = (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
  assign alu_res      = alu_eval(alu_ops_e'(req_ops_i[win]), req_op_a_i[win], req_op_b_i[win]);
  assign lock_abort_o = abort;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    cnt_next   = cnt;
    abort      = 1'b0;
    case (state)
      ARB: begin
        if (hs) begin
          ptr_next = win_inc;
          if (req_lock_i[win]) begin
            state_next = LOCKED;
            owner_next = win;
            cnt_next   = '0;
          end
        end
      end
      LOCKED: begin
        if (hs) begin
          if (req_lock_i[owner]) begin
            cnt_next = '0;
          end else begin
            state_next = ARB;
            ptr_next   = owner_inc;
          end
        end else if (cnt == CNT_W'(LOCK_TIMEOUT-1)) begin
          // An owner that goes quiet (or is stalled) loses the ALU.
          state_next = ARB;
          ptr_next   = owner_inc;
          cnt_next   = '0;
          abort      = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_cmp_o    <= 1'b0;
      rsp_id_o     <= '0;
    end else if (hs) begin
      rsp_valid_o  <= 1'b1;
      rsp_result_o <= alu_res.result;
      rsp_cmp_o    <= alu_res.cmp;
      rsp_id_o     <= win;
    end else if (rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mgt_01_alu_scheduler.sv
// Directed self-checking bench for mgt_01_alu_scheduler (round-robin DUT
// plus a fixed-priority twin sharing the same inputs).
module tb_mgt_01_alu_scheduler;
  import mgt_01_alu_scheduler_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_lock;
  logic [2:0][31:0] op_a;
  logic [2:0][31:0] op_b;
  logic [2:0][3:0]  ops;
  logic             rsp_ready;

  logic [2:0]  req_ready,  fp_req_ready;
  logic        rsp_valid,  fp_rsp_valid;
  logic [31:0] rsp_result, fp_rsp_result;
  logic        rsp_cmp,    fp_rsp_cmp;
  logic [1:0]  rsp_id,     fp_rsp_id;
  logic        lock_abort, fp_lock_abort;

  int checks = 0;
  int errors = 0;

  mgt_01_alu_scheduler #(.NUM_REQ(3), .FIXED_PRIO(0), .LOCK_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_lock_i(req_lock),
    .req_op_a_i(op_a), .req_op_b_i(op_b), .req_ops_i(ops), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_cmp_o(rsp_cmp), .rsp_id_o(rsp_id), .lock_abort_o(lock_abort)
  );

  mgt_01_alu_scheduler #(.NUM_REQ(3), .FIXED_PRIO(1), .LOCK_TIMEOUT(16)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_lock_i(req_lock),
    .req_op_a_i(op_a), .req_op_b_i(op_b), .req_ops_i(ops), .req_ready_o(fp_req_ready),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(fp_rsp_result),
    .rsp_cmp_o(fp_rsp_cmp), .rsp_id_o(fp_rsp_id), .lock_abort_o(fp_lock_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] lock, input logic rdy);
    req_valid = valid;
    req_lock  = lock;
    rsp_ready = rdy;
  endtask

  task automatic setReq(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ops[k]  = op;
    op_a[k] = a;
    op_b[k] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic [31:0] res, input logic cmp, input logic [1:0] id);
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_result"}, rsp_result, res);
    checkOutput({tag, "_cmp"}, 32'(rsp_cmp), 32'(cmp));
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  task automatic aluVector(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic cmp);
    applyStimulus(3'b001, 3'b000, 1'b1);
    setReq(0, op, a, b);
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'b001);
    tick();
    checkRsp(tag, res, cmp, 2'd0);
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    rst_n = 1'b0;
    applyStimulus(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) setReq(k, ALU_ADD, 32'd0, 32'd0);
    #1;
    checkOutput("reset_valid",  32'(rsp_valid), 32'd0);
    checkOutput("reset_result", rsp_result, 32'd0);
    checkOutput("reset_cmp",    32'(rsp_cmp), 32'd0);
    checkOutput("reset_id",     32'(rsp_id), 32'd0);
    checkOutput("reset_abort",  32'(lock_abort), 32'd0);
    checkOutput("reset_ready",  32'(req_ready), 32'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // Round-robin rotation vs fixed priority, all requesters valid.
    for (int k = 0; k < 3; k++) setReq(k, ALU_ADD, 32'(k), 32'd100);
    applyStimulus(3'b111, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(rr_exp[i]));
      checkOutput($sformatf("fp_grant%0d", i), 32'(fp_req_ready), 32'b001);
      tick();
      checkOutput($sformatf("rr_id%0d", i), 32'(rsp_id), (i == 1) ? 32'd1 : (i == 2) ? 32'd2 : 32'd0);
      checkOutput($sformatf("rr_res%0d", i), rsp_result, (i == 1) ? 32'd101 : (i == 2) ? 32'd102 : 32'd100);
    end
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();

    // Single requester ADD.
    setReq(1, ALU_ADD, 32'd5, 32'd7);
    applyStimulus(3'b010, 3'b000, 1'b1);
    #1;
    checkOutput("add_ready", 32'(req_ready), 32'b010);
    tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    checkRsp("add", 32'd12, 1'b0, 2'd1);
    tick();
    checkOutput("drain_valid", 32'(rsp_valid), 32'd0);
    checkOutput("drain_hold",  rsp_result, 32'd12);

    // Backpressure, then no-bubble refill with a signed compare.
    setReq(0, ALU_SUB, 32'd10, 32'd3);
    applyStimulus(3'b001, 3'b000, 1'b0);
    #1;
    checkOutput("sub_ready", 32'(req_ready), 32'b001);
    tick();
    setReq(0, ALU_LT, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall_ready%0d", i), 32'(req_ready), 32'd0);
      checkRsp($sformatf("stall%0d", i), 32'd7, 1'b0, 2'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("refill_ready", 32'(req_ready), 32'b001);
    tick();
    checkRsp("refill_lt", 32'd0, 1'b1, 2'd0);
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();

    // Locked AND/OR pair from requester 2 with others competing (pointer=1).
    setReq(0, ALU_ADD, 32'd3, 32'd4);
    setReq(1, ALU_ADD, 32'd1, 32'd1);
    setReq(2, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
    applyStimulus(3'b111, 3'b100, 1'b1);
    #1;
    checkOutput("lockA_ready", 32'(req_ready), 32'b010);
    tick();
    checkRsp("lockA", 32'd2, 1'b0, 2'd1);
    checkOutput("lockB_ready", 32'(req_ready), 32'b100);
    tick();
    checkRsp("lockB_and", 32'h0000_F000, 1'b0, 2'd2);
    setReq(2, ALU_OR, 32'h0000_F0F0, 32'h0000_0F00);
    req_lock = 3'b000;
    #1;
    checkOutput("lockC_ready", 32'(req_ready), 32'b100);
    tick();
    checkRsp("lockC_or", 32'h0000_FFF0, 1'b0, 2'd2);
    checkOutput("lockD_ready", 32'(req_ready), 32'b001);
    tick();
    checkRsp("lockD", 32'd7, 1'b0, 2'd0);
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();

    // Lock timeout: owner 2 goes idle, others blocked for 16 cycles.
    applyStimulus(3'b100, 3'b100, 1'b1);
    #1;
    checkOutput("to_lock_ready", 32'(req_ready), 32'b100);
    tick();
    applyStimulus(3'b011, 3'b000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      #1;
      checkOutput($sformatf("to_block%0d", i), 32'(req_ready), 32'd0);
      checkOutput($sformatf("to_abort%0d", i), 32'(lock_abort), (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    checkOutput("to_after_ready", 32'(req_ready), 32'b001);
    checkOutput("to_after_abort", 32'(lock_abort), 32'd0);
    tick();

    // Asynchronous reset while locked with a buffered response.
    applyStimulus(3'b010, 3'b010, 1'b1);
    #1;
    checkOutput("rst_lock_ready", 32'(req_ready), 32'b010);
    tick();
    applyStimulus(3'b000, 3'b000, 1'b0);
    checkOutput("rst_pre_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid",  32'(rsp_valid), 32'd0);
    checkOutput("rst_result", rsp_result, 32'd0);
    checkOutput("rst_cmp",    32'(rsp_cmp), 32'd0);
    checkOutput("rst_id",     32'(rsp_id), 32'd0);
    checkOutput("rst_abort",  32'(lock_abort), 32'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(3'b111, 3'b000, 1'b1);
    #1;
    checkOutput("rst_arb_ptr0", 32'(req_ready), 32'b001);
    tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();

    // ALU corner cases through requester 0.
    aluVector("sll32",  ALU_SLL, 32'd1,         32'd32,        32'd0,          1'b0);
    aluVector("sll4",   ALU_SLL, 32'd1,         32'd4,         32'd16,         1'b0);
    aluVector("sra40",  ALU_SRA, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF,  1'b0);
    aluVector("srl31",  ALU_SRL, 32'h8000_0000, 32'd31,        32'd1,          1'b0);
    aluVector("sub",    ALU_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE,  1'b0);
    aluVector("xor",    ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0,  1'b0);
    aluVector("ltu",    ALU_LTU, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b0);
    aluVector("ge",     ALU_GE,  32'd5,         32'd5,         32'd0,          1'b1);
    aluVector("geu",    ALU_GEU, 32'd1,         32'hFFFF_FFFF, 32'd0,          1'b0);
    aluVector("eq",     ALU_EQ,  32'd3,         32'd3,         32'd0,          1'b1);
    aluVector("ne",     ALU_NE,  32'd3,         32'd3,         32'd0,          1'b0);
    aluVector("unused", 4'hF,    32'd5,         32'd5,         32'd0,          1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mgt_01_alu_scheduler.md
Name: mgt_01_alu_scheduler

Overview:
- Shares the single core ALU among NUM_REQ requesters: integer pipe (0), branch unit (1) and CSR unit (2).
- Arbitrates valid/ready requests and drives the combinational ALU.
- Registers the result plus comparison flag into a one-entry response buffer, tagged with the requester id.
- Supports locked sequences so a CSR read-modify-write keeps the ALU for back-to-back operations.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- FIXED_PRIO, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- LOCK_TIMEOUT, 16: idle cycles of a lock owner before the lock is force-released (≥2).

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  request valid, one bit per requester
- req_lock_i  in  NUM_REQ  keep grant after this op
- req_op_a_i  in  NUM_REQ x 32  operand A per requester (data_u)
- req_op_b_i  in  NUM_REQ x 32  operand B per requester (data_u)
- req_ops_i  in  NUM_REQ x alu_ops_e  ALU operation per requester
- req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- rsp_valid_o  out  1  response buffer full
- rsp_ready_i  in  1  consumer takes response
- rsp_result_o  out  32  ALU result (data_bus_t)
- rsp_cmp_o  out  1  comparison flag
- rsp_id_o  out  $clog2(NUM_REQ)  requester index of response
- lock_abort_o  out  1  one-cycle pulse on lock timeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_n_i, asynchronous, active-low.
- Reset values:
  - rsp_valid_o=0, rsp_result_o=0, rsp_cmp_o=0, rsp_id_o=0, lock_abort_o=0.
  - RR pointer=0, FSM=ARB, timeout counter=0.
  - Reset mid-operation drops the buffered response and any lock, with no pulse.
- Buffer state: can_accept = ~rsp_valid_o | rsp_ready_i.
- Grant:
  - At most one req_ready_o bit is high, and only when can_accept.
  - Handshake = req_valid_i[k] & req_ready_o[k].
  - req_ready_o is combinational from valid, FSM, pointer and can_accept. It never depends on rsp_ready_i except through can_accept.
- Latency: exactly 1 cycle.
  - On handshake, the ALU is evaluated with the winner's operands and op.
  - result, cmp and id are registered; rsp_valid_o=1 next cycle.
- Backpressure:
  - While rsp_valid_o & ~rsp_ready_i, all response outputs hold stable.
  - Simultaneous drain and accept loads the new entry with no bubble.
  - Drain with no accept clears rsp_valid_o; data outputs hold their last value.
- Round-robin (FIXED_PRIO=0):
  - Search starts at the pointer and wraps NUM_REQ-1 -> 0.
  - The pointer moves to winner+1 (mod NUM_REQ) only on a handshake in ARB.
  - With no valid requests, or while stalled, the pointer is unchanged.
- FSM states:
  - ARB: normal arbitration. A handshake with req_lock_i[w]=1 goes to LOCKED, owner=w, counter=0.
  - LOCKED: only the owner may be granted; all other req_ready_o stay 0 even if the buffer is free.
    - Owner handshake with lock=1 stays in LOCKED and clears the counter.
    - Owner handshake with lock=0 goes to ARB and sets pointer=owner+1.
    - Owner idle (no handshake) increments the counter. At LOCK_TIMEOUT-1 the FSM goes to ARB, pulses lock_abort_o for one cycle and sets pointer=owner+1.
    - A stall caused by a full buffer also counts as idle.
- ALU op semantics:
  - Arithmetic/logic ops produce a result with cmp=0.
  - Compare ops (EQ, NE, LT, LTU, GE, GEU) produce cmp with result=0.
  - Unused ops produce 0/0.
  - Shifts use the full operand B as issued by the requester.

Decomposition:
- Shared package (Modules_pkg): alu_ops_e, data_u, data_bus_t (existing); new sched_state_e {ARB, LOCKED}; parameter constant SCHED_ID_W.
- Sub-module mgt_01_rr_arbiter: parameterised NUM_REQ, request/pointer in, one-hot grant plus binary index out, with a fixed-priority mode. The scheduler instantiates it once plus the core ALU.

Test Plan:
- Only req 1 valid (ADD, A=5, B=7), rsp_ready_i=1 -> req_ready_o=3'b010 same cycle; next cycle rsp_valid_o=1, result=12, id=1.
- All three valid continuously, RR mode -> grants in order 0,1,2,0 one per cycle; FIXED_PRIO=1 -> req 0 granted every cycle.
- rsp_ready_i=0 for 3 cycles with SUB A=10, B=3 buffered -> result=7 held stable, req_ready_o=0; rsp_ready_i=1 with new SLT request -> no bubble, next rsp_cmp_o reflects LT.
- Req 2 ops {AND lock=1, OR lock=0} with reqs 0 and 1 valid -> req 2 served twice back-to-back, then grant goes to 0.
- Req 2 locks then drops valid, LOCK_TIMEOUT=16 -> others blocked 16 cycles, lock_abort_o pulses once, req 0 granted next.
- rst_n_i low mid-LOCKED with rsp_valid_o=1 -> all outputs 0 immediately (asynchronous), FSM=ARB, pointer=0.
